// File: rtl/decode_rp_pkg.sv
// rtl/decode_rp_pkg.sv - shared state encoding, mode constants and per-level parameter tables
`ifndef RP_DEPTH
`define RP_DEPTH 10
`endif
`ifndef RP_D_SIZE
`define RP_D_SIZE 14
`endif
`ifndef RP_INV_SIZE
`define RP_INV_SIZE 16
`endif
`ifndef OUT_DEPTH
`define OUT_DEPTH 10
`endif

package decode_rp_pkg;

  localparam int NLVL  = 11;
  localparam int DRAIN = 4;
  localparam int CNT_W = 3;
  localparam int RD_W  = `RP_DEPTH;
  localparam int D_W   = `RP_D_SIZE;
  localparam int INV_W = `RP_INV_SIZE;
  localparam int OUT_W = `OUT_DEPTH;

  localparam logic MODE_CT = 1'b0;
  localparam logic MODE_PK = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DRAIN, S_ACK} state_e;

  typedef struct packed {
    logic [4:0]       state_max;
    logic [RD_W-2:0]  r_max;
    logic [RD_W-2:0]  ri_offset;
    logic [RD_W-2:0]  ro_offset;
    logic [RD_W-1:0]  ro_max;
    logic [D_W-1:0]   m0;
    logic [INV_W-1:0] m0inv;
    logic [1:0]       outs1;
    logic [1:0]       outsl;
    logic [1:0]       outsl_first;
    logic [1:0]       r_s1;
    logic [1:0]       r_sl;
    logic [OUT_W-1:0] outoffset;
  } param_t;

  // Row 0 is the ciphertext (CT) mode, row 1 the public-key (PK) mode.
  localparam logic [RD_W-2:0] R_MAX_T [2][NLVL] = '{
    '{380, 190, 95, 47, 23, 11, 5, 2, 1, 1, 0},
    '{400, 200, 100, 50, 25, 12, 6, 3, 1, 1, 0}};
  localparam logic [RD_W-2:0] RI_OFF_T [2][NLVL] = '{
    '{0, 32, 64, 96, 128, 160, 192, 224, 256, 288, 320},
    '{0, 40, 80, 120, 160, 200, 240, 280, 320, 360, 400}};
  localparam logic [1:0] OUTS1_T [2][NLVL] = '{
    '{1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 2},
    '{2, 2, 2, 2, 1, 1, 1, 1, 1, 1, 3}};
  localparam logic [1:0] OUTSL_T [2][NLVL] = '{
    '{2, 2, 1, 1, 1, 1, 1, 1, 1, 1, 3},
    '{1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 0}};
  localparam logic [OUT_W-1:0] OUTOFF_T [2][NLVL] = '{
    '{0, 50, 100, 150, 200, 250, 300, 350, 400, 450, 500},
    '{0, 60, 120, 180, 240, 300, 360, 420, 480, 540, 600}};
  localparam logic [RD_W-2:0] RO_OFF_T [2][NLVL] = '{
    '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110},
    '{5, 15, 25, 35, 45, 55, 65, 75, 85, 95, 105}};
  localparam logic [1:0] R_S1_T [2][NLVL] = '{
    '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2},
    '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2, 1}};
  localparam logic [1:0] R_SL_T [2][NLVL] = '{
    '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 3},
    '{2, 2, 2, 2, 1, 1, 1, 1, 1, 3, 0}};
  localparam logic [D_W-1:0] M0_T [2][NLVL] = '{
    '{4591, 322, 406, 644, 1621, 10265, 1608, 11550, 1557, 2352, 9157},
    '{4621, 1542, 2310, 3465, 5197, 7796, 11694, 1052, 1578, 2367, 3551}};
  localparam logic [INV_W-1:0] M0INV_T [2][NLVL] = '{
    '{3654, 52101, 41321, 26050, 10349, 1634, 10433, 1452, 10772, 7133, 1832},
    '{3630, 10879, 7262, 4841, 3227, 2152, 1434, 15947, 10632, 7088, 4724}};

  function automatic logic [4:0] state_max_f(input logic m);
    return m ? 5'd9 : 5'd10;
  endfunction

  function automatic logic [RD_W-1:0] ro_max_f(input logic m);
    return m ? RD_W'(857) : RD_W'(761);
  endfunction

  function automatic logic [1:0] outsl_first_f(input logic m);
    return m ? 2'd2 : 2'd1;
  endfunction

  // Indices past the last level (the decoder parks at 31 when done) read the last entry.
  function automatic logic [3:0] clamp_idx(input logic m, input logic [4:0] idx);
    logic [4:0] c;
    c = (idx > state_max_f(m)) ? state_max_f(m) : idx;
    return c[3:0];
  endfunction

  function automatic logic [RD_W-2:0] r_max_f(input logic m, input logic [3:0] i); return R_MAX_T[m][i]; endfunction
  function automatic logic [RD_W-2:0] ri_offset_f(input logic m, input logic [3:0] i); return RI_OFF_T[m][i]; endfunction
  function automatic logic [1:0] outs1_f(input logic m, input logic [3:0] i); return OUTS1_T[m][i]; endfunction
  function automatic logic [1:0] outsl_f(input logic m, input logic [3:0] i); return OUTSL_T[m][i]; endfunction
  function automatic logic [OUT_W-1:0] outoffset_f(input logic m, input logic [3:0] i); return OUTOFF_T[m][i]; endfunction
  function automatic logic [RD_W-2:0] ro_offset_f(input logic m, input logic [3:0] i); return RO_OFF_T[m][i]; endfunction
  function automatic logic [1:0] r_s1_f(input logic m, input logic [3:0] i); return R_S1_T[m][i]; endfunction
  function automatic logic [1:0] r_sl_f(input logic m, input logic [3:0] i); return R_SL_T[m][i]; endfunction
  function automatic logic [D_W-1:0] m0_f(input logic m, input logic [3:0] i); return M0_T[m][i]; endfunction
  function automatic logic [INV_W-1:0] m0inv_f(input logic m, input logic [3:0] i); return M0INV_T[m][i]; endfunction

endpackage

// File: rtl/decode_rp_param_rom.sv
// rtl/decode_rp_param_rom.sv - combinational per-level parameter lookup for the R/q decoder
module decode_rp_param_rom
  import decode_rp_pkg::*;
(
  input  logic       mode_i,
  input  logic [4:0] l_idx_i,
  input  logic [4:0] s_idx_i,
  output param_t     param_o
);

  logic [3:0] l_c;
  logic [3:0] s_c;

  always_comb begin
    l_c     = clamp_idx(mode_i, l_idx_i);
    s_c     = clamp_idx(mode_i, s_idx_i);
    param_o = '0;
    param_o.state_max   = state_max_f(mode_i);
    param_o.ro_max      = ro_max_f(mode_i);
    param_o.outsl_first = outsl_first_f(mode_i);
    param_o.r_max       = r_max_f(mode_i, l_c);
    param_o.ri_offset   = ri_offset_f(mode_i, l_c);
    param_o.outs1       = outs1_f(mode_i, l_c);
    param_o.outsl       = outsl_f(mode_i, l_c);
    param_o.outoffset   = outoffset_f(mode_i, l_c);
    // The short side trails the long side by three pipeline stages, hence its own index.
    param_o.ro_offset   = ro_offset_f(mode_i, s_c);
    param_o.r_s1        = r_s1_f(mode_i, s_c);
    param_o.r_sl        = r_sl_f(mode_i, s_c);
    param_o.m0          = m0_f(mode_i, s_c);
    param_o.m0inv       = m0inv_f(mode_i, s_c);
  end

endmodule

// File: rtl/decode_rp_ctrl.sv
// rtl/decode_rp_ctrl.sv - round-robin sequencer for the shared R/q decoder; DECODE_RP_CTRL_WDOG_EN adds a RUN watchdog and err
module decode_rp_ctrl
  import decode_rp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  output logic [1:0]        ack,
`ifdef DECODE_RP_CTRL_WDOG_EN
  output logic              err,
`endif
  output logic              busy,
  output logic              dec_start,
  input  logic              dec_done,
  input  logic [4:0]        dec_state_l,
  input  logic [4:0]        dec_state_s,
  output logic [4:0]        state_max,
  output logic [RD_W-2:0]   param_r_max,
  output logic [RD_W-2:0]   param_ri_offset,
  output logic [RD_W-2:0]   param_ro_offset,
  output logic [RD_W-1:0]   param_ro_max,
  output logic [D_W-1:0]    param_m0,
  output logic [INV_W-1:0]  param_m0inv,
  output logic [1:0]        param_outs1,
  output logic [1:0]        param_outsl,
  output logic [1:0]        param_outsl_first,
  output logic [1:0]        param_r_s1,
  output logic [1:0]        param_r_sl,
  output logic [OUT_W-1:0]  param_outoffset,
  output logic              mode
);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef DECODE_RP_CTRL_WDOG_EN
  logic [15:0]      wdog_q, wdog_d;
  logic             err_q, err_d;
`endif
  param_t           param;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_CT;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
`ifdef DECODE_RP_CTRL_WDOG_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
`ifdef DECODE_RP_CTRL_WDOG_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

  // cnt_q is reused: START length, first-RUN-cycle guard, then DRAIN countdown.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
`ifdef DECODE_RP_CTRL_WDOG_EN
    wdog_d  = wdog_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          mode_d  = (req == 2'b11) ? rr_q : req[1];
          cnt_d   = CNT_W'(1);
          state_d = S_START;
`ifdef DECODE_RP_CTRL_WDOG_EN
          wdog_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(1);
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RUN: begin
`ifdef DECODE_RP_CTRL_WDOG_EN
        wdog_d = wdog_q + 16'd1;
`endif
        if (cnt_q != '0) begin
          cnt_d = '0;
        end else if (dec_done) begin
          cnt_d   = CNT_W'(DRAIN - 1);
          state_d = S_DRAIN;
        end
`ifdef DECODE_RP_CTRL_WDOG_EN
        else if (wdog_d == 16'hFFFF) begin
          err_d   = 1'b1;
          state_d = S_ACK;
        end
`endif
      end
      S_DRAIN: begin
        if (cnt_q == '0) state_d = S_ACK;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_ACK: begin
        rr_d    = ~mode_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dec_start = (state_q == S_START);
  assign busy      = (state_q == S_START) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign ack       = (state_q != S_ACK) ? 2'b00 : (mode_q ? 2'b10 : 2'b01);
  assign mode      = mode_q;
`ifdef DECODE_RP_CTRL_WDOG_EN
  assign err       = (state_q == S_ACK) && err_q;
`endif

  decode_rp_param_rom u_rom (
    .mode_i  (mode_q),
    .l_idx_i (dec_state_l),
    .s_idx_i (dec_state_s),
    .param_o (param)
  );

  assign state_max         = param.state_max;
  assign param_r_max       = param.r_max;
  assign param_ri_offset   = param.ri_offset;
  assign param_ro_offset   = param.ro_offset;
  assign param_ro_max      = param.ro_max;
  assign param_m0          = param.m0;
  assign param_m0inv       = param.m0inv;
  assign param_outs1       = param.outs1;
  assign param_outsl       = param.outsl;
  assign param_outsl_first = param.outsl_first;
  assign param_r_s1        = param.r_s1;
  assign param_r_sl        = param.r_sl;
  assign param_outoffset   = param.outoffset;

endmodule
